// File: rtl/envelope_adsr_pkg.sv
// Shared types, state encoding and step scaling for the ADSR envelope.
// Rates are 8-bit; a rate step is the rate scaled up by 16 into the level range.
package envelope_adsr_pkg;

    typedef logic [15:0]        env_t;
    typedef logic signed [15:0] volt_t;
    typedef logic [7:0]         rate_t;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    localparam int STEP_SHIFT = 4;

    function automatic logic [7+STEP_SHIFT:0] step_of(input rate_t r);
        return {r, {STEP_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/envelope_mult.sv
// Registered signed sample x unsigned level, keeping the top VOLT_W bits (floor); 1-cycle latency.
// Free-running, no backpressure; a zero level forces an exact zero output.
module envelope_mult #(
    parameter int VOLT_W = 16,
    parameter int ENV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VOLT_W-1:0] v_in,
    input  logic [ENV_W-1:0]  level,
    output logic [VOLT_W-1:0] v_out
);
    localparam int PW = VOLT_W + ENV_W + 1;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;
    logic          unused_prod_bits;

    // Both operands widened to the full product width, so a plain modular
    // multiply yields the exact two's-complement product.
    assign a_ext = {{(ENV_W+1){v_in[VOLT_W-1]}}, v_in};
    assign b_ext = {{(VOLT_W+1){1'b0}}, level};
    assign prod  = a_ext * b_ext;
    assign unused_prod_bits = ^{prod[ENV_W-1:0], prod[PW-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_out <= '0;
        end else begin
            v_out <= (level == '0) ? '0 : prod[ENV_W +: VOLT_W];
        end
    end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope: gate edges move the phase on any cycle, level moves only on ticks; v_out lags env_level by 1 cycle.
// Free-running, no backpressure. ENV_EXP_RELEASE_EN selects an exponential release tail.
module envelope_adsr
    import envelope_adsr_pkg::*;
#(
    parameter int TICK_DIV = 1024,
    parameter int ENV_W    = 16,
    parameter int VOLT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gate,
    input  logic [VOLT_W-1:0] v_in,
    input  logic [7:0]        attack_rate,
    input  logic [7:0]        decay_rate,
    input  logic [7:0]        sustain_level,
    input  logic [7:0]        release_rate,
    output logic [VOLT_W-1:0] v_out,
    output logic [ENV_W-1:0]  env_level,
    output logic              active
);
    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [ENV_W-1:0] LVL_MAX = '1;

    env_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick, gate_d, rise, fall, active_q;
    logic [ENV_W-1:0] level, level_nxt;
    logic [ENV_W-1:0] a_step, d_step, r_step, sus;
    logic [ENV_W:0]   att_sum, dec_diff;
    logic [ENV_W-1:0] att_lvl, dec_lvl, rel_lvl;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));
    assign rise = gate & ~gate_d;
    assign fall = ~gate & gate_d;

    assign a_step = ENV_W'(step_of(attack_rate));
    assign d_step = ENV_W'(step_of(decay_rate));
    assign sus    = ENV_W'({sustain_level, sustain_level});

    assign att_sum  = {1'b0, level} + {1'b0, a_step};
    assign att_lvl  = att_sum[ENV_W] ? LVL_MAX : att_sum[ENV_W-1:0];
    assign dec_diff = {1'b0, level} - {1'b0, d_step};
    assign dec_lvl  = (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] < sus)) ? sus : dec_diff[ENV_W-1:0];

`ifdef ENV_EXP_RELEASE_EN
    logic [ENV_W-1:0] exp_dec;
    logic             unused_rel_hi;
    // A shift of zero makes the decrement the whole level, emptying it in one tick.
    always_comb begin
        exp_dec = level >> release_rate[3:0];
        if (exp_dec == '0) exp_dec = ENV_W'(1);
    end
    assign r_step        = exp_dec;
    assign unused_rel_hi = ^release_rate[7:4];
`else
    assign r_step = ENV_W'(step_of(release_rate));
`endif
    assign rel_lvl = (level > r_step) ? level - r_step : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ENV_IDLE;
            level    <= '0;
            active_q <= 1'b0;
            cnt      <= '0;
            gate_d   <= 1'b0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            active_q <= (state_nxt != ENV_IDLE);
            cnt      <= tick ? '0 : cnt + CNT_W'(1);
            gate_d   <= gate;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENV_IDLE:    if (rise) state_nxt = ENV_ATTACK;
            ENV_ATTACK:  if (fall) state_nxt = ENV_RELEASE;
                         else if (tick && att_lvl == LVL_MAX) state_nxt = ENV_DECAY;
            ENV_DECAY:   if (fall) state_nxt = ENV_RELEASE;
                         else if (tick && dec_lvl == sus) state_nxt = ENV_SUSTAIN;
            ENV_SUSTAIN: if (fall) state_nxt = ENV_RELEASE;
            ENV_RELEASE: if (rise) state_nxt = ENV_ATTACK;
                         else if (tick && rel_lvl == '0) state_nxt = ENV_IDLE;
            default:     state_nxt = ENV_IDLE;
        endcase
    end

    // A gate-edge transition freezes the level for that cycle, even on a tick.
    always_comb begin
        level_nxt = level;
        case (state)
            ENV_IDLE:    level_nxt = '0;
            ENV_ATTACK:  if (!fall && tick) level_nxt = att_lvl;
            ENV_DECAY:   if (!fall && tick) level_nxt = dec_lvl;
            ENV_SUSTAIN: if (!fall) level_nxt = sus;
            ENV_RELEASE: if (!rise && tick) level_nxt = rel_lvl;
            default:     level_nxt = '0;
        endcase
    end

    assign env_level = level;
    assign active    = active_q;

    envelope_mult #(
        .VOLT_W (VOLT_W),
        .ENV_W  (ENV_W)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .v_in   (v_in),
        .level  (level),
        .v_out  (v_out)
    );

endmodule
